// File: rtl/gige_mdio_master.sv
`timescale 1ns/1ps
// Clause 22 MDIO master: serialises one register read or write per command onto MDC/MDIO.
// Define MDIO_PREAMBLE_SUPPRESS_EN to send the 32-bit preamble only on the first frame after reset.
module gige_mdio_master #(
  parameter int CLK_DIV = 20
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] BIT_LAST  = 9'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_GAP, S_DONE
  } state_e;

  state_e      state_q;
  logic [8:0]  div_q;
  logic [4:0]  bit_q;
  logic [31:0] tx_q;
  logic        wr_q;
  logic [15:0] rx_q;
  logic        ta_q;
  logic        sync1_q;
  logic        sync2_q;
  logic        mdc_q;
  logic        mdio_o_q;
  logic        mdio_oe_q;
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_rdata_q;
  logic        rsp_error_q;

  logic [31:0] tx_d;
  logic [31:0] tx_shift;
  logic        skip_pre;
  logic        bit_end;

  // ST, OP, PHYAD, REGAD, TA and data in wire order; read TA/data slots are never driven.
  assign tx_d     = {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy_addr, cmd_reg_addr,
                     2'b10, (cmd_write ? cmd_wdata : 16'h0000)};
  assign tx_shift = {tx_q[30:0], 1'b0};
  assign bit_end  = (div_q == BIT_LAST);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  logic pre_done_q;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      pre_done_q <= 1'b0;
    end else if (state_q == S_IDLE && cmd_valid) begin
      pre_done_q <= 1'b1;
    end
  end

  assign skip_pre = pre_done_q;
`else
  assign skip_pre = 1'b0;
`endif

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= mdio_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      wr_q        <= 1'b0;
      rx_q        <= '0;
      ta_q        <= 1'b0;
      mdc_q       <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            wr_q        <= cmd_write;
            cmd_ready_q <= 1'b0;
            div_q       <= '0;
            bit_q       <= '0;
            mdc_q       <= 1'b0;
            mdio_oe_q   <= 1'b1;
            if (skip_pre) begin
              state_q  <= S_HDR;
              mdio_o_q <= tx_d[31];
              tx_q     <= {tx_d[30:0], 1'b0};
            end else begin
              state_q  <= S_PRE;
              mdio_o_q <= 1'b1;
              tx_q     <= tx_d;
            end
          end
        end

        S_DONE: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end

        default: begin
          if (div_q == HALF_LAST) begin
            mdc_q <= 1'b1;
          end
          if (!bit_end) begin
            div_q <= div_q + 9'd1;
          end else begin
            // Bit boundary: MDC falls and the next bit is presented.
            div_q <= '0;
            mdc_q <= 1'b0;
            case (state_q)
              S_PRE: begin
                if (bit_q == 5'd31) begin
                  state_q  <= S_HDR;
                  bit_q    <= '0;
                  mdio_o_q <= tx_q[31];
                  tx_q     <= tx_shift;
                end else begin
                  bit_q <= bit_q + 5'd1;
                end
              end

              S_HDR: begin
                tx_q <= tx_shift;
                if (bit_q == 5'd13) begin
                  state_q <= S_TA;
                  bit_q   <= '0;
                  if (wr_q) begin
                    mdio_o_q <= tx_q[31];
                  end else begin
                    mdio_oe_q <= 1'b0;
                    mdio_o_q  <= 1'b1;
                  end
                end else begin
                  bit_q    <= bit_q + 5'd1;
                  mdio_o_q <= tx_q[31];
                end
              end

              S_TA: begin
                tx_q <= tx_shift;
                if (wr_q) begin
                  mdio_o_q <= tx_q[31];
                end
                if (bit_q == 5'd1) begin
                  ta_q    <= sync2_q;
                  state_q <= S_DATA;
                  bit_q   <= '0;
                end else begin
                  bit_q <= bit_q + 5'd1;
                end
              end

              S_DATA: begin
                rx_q <= {rx_q[14:0], sync2_q};
                tx_q <= tx_shift;
                if (bit_q == 5'd15) begin
                  state_q   <= S_GAP;
                  bit_q     <= '0;
                  mdio_oe_q <= 1'b0;
                  mdio_o_q  <= 1'b1;
                end else begin
                  bit_q <= bit_q + 5'd1;
                  if (wr_q) begin
                    mdio_o_q <= tx_q[31];
                  end
                end
              end

              default: begin
                state_q     <= S_DONE;
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= wr_q ? 16'h0000 : rx_q;
                rsp_error_q <= wr_q ? 1'b0 : ta_q;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign mdc       = mdc_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_oe   = mdio_oe_q;

endmodule

// File: tb/tb_gige_mdio_master.sv
`timescale 1ns/1ps
// Bench for gige_mdio_master: directed commands with a PHY model; a scoreboard checks each rsp_valid.
module tb_gige_mdio_master;
  localparam int DIV = 4;

  logic        clk_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_phy_addr = '0;
  logic [4:0]  cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_oe;
  logic        mdio_i;

  logic        phy_en = 1'b0;
  logic        phy_val = 1'b1;
  assign mdio_i = mdio_oe ? mdio_o : (phy_en ? phy_val : 1'b1);

  always #10 clk_50 = ~clk_50;

  gige_mdio_master #(.CLK_DIV(DIV)) dut (
    .clk_50(clk_50), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          nbits;
    int          pre;
    logic [64:0] oe;
    logic [64:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  cap_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cycle = 0;
  int          acc_count = 0;
  int          rsp_cycle = 0;
  int          rsp_count = 0;
  int          rise_cnt = 0;
  int          phy_ta0 = 0;
  int          last_pre = 32;
  logic [15:0] phy_data = '0;
  logic        phy_on = 1'b0;
  logic        first_frame = 1'b1;
  logic        busy_chk = 1'b0;
  logic [31:0] last_word = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic int next_pre();
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    int p = first_frame ? 32 : 0;
`else
    int p = 32;
`endif
    first_frame = 1'b0;
    return p;
  endfunction

  // Expected frame built from the command fields: preamble, ST/OP/PHYAD/REGAD, TA, data, GAP.
  function automatic exp_t make_exp(logic wr, logic [4:0] phy, logic [4:0] rg, logic [15:0] wd,
                                    logic [15:0] rd, logic er, int pre);
    exp_t        e;
    logic [31:0] w;
    int          n = 0;
    w = {2'b01, (wr ? 2'b01 : 2'b10), phy, rg, 2'b10, (wr ? wd : 16'h0000)};
    e.oe  = '0;
    e.val = '0;
    for (int i = 0; i < pre; i++) begin
      e.oe[n] = 1'b1; e.val[n] = 1'b1; n++;
    end
    for (int k = 0; k < 32; k++) begin
      if (k < 14 || wr) begin
        e.oe[n] = 1'b1; e.val[n] = w[31-k];
      end
      n++;
    end
    n++;
    e.nbits = n;
    e.pre   = pre;
    e.lat   = 1 + n * 2 * DIV;
    e.rdata = wr ? 16'h0000 : rd;
    e.err   = wr ? 1'b0 : er;
    return e;
  endfunction

  always @(posedge clk_50) cyc++;

  always @(posedge mdc) begin
    #1;
    cap_q.push_back({mdio_oe, mdio_o});
  end

  // PHY: releases through TA bit 0, then drives TA=0 and 16 data bits, each 100 ns after MDC rises.
  always @(posedge mdc) begin
    int rc;
    rise_cnt = rise_cnt + 1;
    rc = rise_cnt;
    if (phy_on && rc >= phy_ta0 && rc <= phy_ta0 + 17) begin
      #100;
      if (rc == phy_ta0 + 17) begin
        phy_en = 1'b0;
      end else begin
        phy_en  = 1'b1;
        phy_val = (rc == phy_ta0) ? 1'b0 : phy_data[phy_ta0 + 16 - rc];
      end
    end
  end

  always @(negedge clk_50) begin
    exp_t e;
    int   mism;
    if (reset_n) begin
      if (cmd_valid && cmd_ready) begin
        if (busy_chk) check("b2b_accept_after_rsp", 32'(cyc - rsp_cycle), 32'd1);
        acc_cycle = cyc;
        acc_count++;
        cap_q.delete();
        rise_cnt = 0;
      end
      if (rsp_valid) begin
        rsp_cycle = cyc;
        rsp_count++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: actual rsp_valid=1 required no response");
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          check("rsp_error", 32'(rsp_error), 32'(e.err));
          check("rsp_latency", 32'(cyc - acc_cycle), 32'(e.lat));
          check("frame_len", 32'(cap_q.size()), 32'(e.nbits));
          mism = 0;
          for (int j = 0; j < e.nbits && j < cap_q.size(); j++) begin
            if (cap_q[j][1] !== e.oe[j]) mism++;
            else if (e.oe[j] && cap_q[j][0] !== e.val[j]) mism++;
          end
          check("frame_bits_bad", 32'(mism), 32'd0);
          last_word = '0;
          for (int j = 0; j < 32; j++)
            if (e.pre + j < cap_q.size()) last_word = {last_word[30:0], cap_q[e.pre + j][0]};
        end
      end
    end
  end

  task automatic issue(logic wr, logic [4:0] phy, logic [4:0] rg, logic [15:0] wd,
                       logic [15:0] rd, logic er);
    int t = 0;
    @(posedge clk_50); #2;
    while (!cmd_ready && t < 3000) begin
      @(posedge clk_50); #2; t++;
    end
    last_pre = next_pre();
    phy_ta0  = last_pre + 15;
    phy_data = rd;
    exp_q.push_back(make_exp(wr, phy, rg, wd, rd, er, last_pre));
    cmd_write = wr; cmd_phy_addr = phy; cmd_reg_addr = rg; cmd_wdata = wd;
    cmd_valid = 1'b1;
    @(posedge clk_50); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(int n_before, string name);
    int t = 0;
    while (rsp_count == n_before && t < 3000) begin
      @(posedge clk_50); t++;
    end
    if (rsp_count == n_before) begin
      checks++; errors++;
      $display("FAIL %s_timeout: actual no rsp_valid in %0d cycles required one", name, t);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_mdc"}, 32'(mdc), 32'd0);
    check({tag, "_mdio_o"}, 32'(mdio_o), 32'd1);
    check({tag, "_mdio_oe"}, 32'(mdio_oe), 32'd0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
  endtask

  initial begin
    int n;
    int a0;
    int t;
    repeat (3) @(posedge clk_50);
    @(negedge clk_50);
    check_reset_outputs("reset");
    #3 reset_n = 1'b1;

    // Write PHYAD=0x10 REGAD=0x00 data 0x8140: header+TA+data must read 0x58028140 on the wire.
    n = rsp_count;
    issue(1'b1, 5'h10, 5'h00, 16'h8140, 16'h0000, 1'b0);
    wait_rsp(n, "write_8140");
    check("write_wire_word", last_word, 32'h5802_8140);

    // Read with PHY answering 0x0141.
    phy_on = 1'b1;
    n = rsp_count;
    issue(1'b0, 5'h01, 5'h02, 16'h0000, 16'h0141, 1'b0);
    wait_rsp(n, "read_0141");

    // Read with PHY answering 0xA5C3 on the highest addresses.
    n = rsp_count;
    issue(1'b0, 5'h1F, 5'h1F, 16'h0000, 16'hA5C3, 1'b0);
    wait_rsp(n, "read_a5c3");
    phy_on = 1'b0;
    phy_en = 1'b0;

    // Read with no PHY: pull-up gives all ones and an error.
    n = rsp_count;
    issue(1'b0, 5'h07, 5'h01, 16'h0000, 16'hFFFF, 1'b1);
    wait_rsp(n, "read_nophy");

    // Write all ones to boundary addresses.
    n = rsp_count;
    issue(1'b1, 5'h00, 5'h1F, 16'hFFFF, 16'h0000, 1'b0);
    wait_rsp(n, "write_ffff");

    // Busy: cmd_valid held high, fields scrambled mid-frame, then a back-to-back command.
    n  = rsp_count;
    a0 = acc_count;
    @(posedge clk_50); #2;
    last_pre = next_pre();
    exp_q.push_back(make_exp(1'b1, 5'h05, 5'h0A, 16'h3C5A, 16'h0000, 1'b0, last_pre));
    cmd_write = 1'b1; cmd_phy_addr = 5'h05; cmd_reg_addr = 5'h0A; cmd_wdata = 16'h3C5A;
    cmd_valid = 1'b1;
    t = 0;
    while (t < 3000) begin
      @(posedge clk_50); #2; t++;
      if (rsp_valid) break;
      if (!cmd_ready) begin
        cmd_write = 1'($urandom); cmd_phy_addr = 5'($urandom);
        cmd_reg_addr = 5'($urandom); cmd_wdata = 16'($urandom);
      end
    end
    check("busy_single_accept", 32'(acc_count - a0), 32'd1);
    last_pre = next_pre();
    exp_q.push_back(make_exp(1'b0, 5'h03, 5'h04, 16'h0000, 16'hFFFF, 1'b1, last_pre));
    cmd_write = 1'b0; cmd_phy_addr = 5'h03; cmd_reg_addr = 5'h04; cmd_wdata = 16'h0000;
    busy_chk = 1'b1;
    @(posedge clk_50); #2;
    @(posedge clk_50); #2;
    cmd_valid = 1'b0;
    busy_chk  = 1'b0;
    check("busy_second_accept", 32'(acc_count - a0), 32'd2);
    wait_rsp(n + 1, "busy_b2b");

    // Reset pulsed during DATA bit 5 of a write.
    n = rsp_count;
    issue(1'b1, 5'h0C, 5'h03, 16'h5555, 16'h0000, 1'b0);
    t = 0;
    while (rise_cnt < last_pre + 22 && t < 3000) begin
      @(posedge clk_50); t++;
    end
    check("reach_data_bit5", 32'(rise_cnt >= last_pre + 22), 32'd1);
    #33 reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    cap_q.delete();
    rise_cnt = 0;
    first_frame = 1'b1;
    repeat (3) @(posedge clk_50);
    #3 reset_n = 1'b1;
    repeat (600) @(posedge clk_50);
    check("no_rsp_after_reset", 32'(rsp_count), 32'(n));

    n = rsp_count;
    issue(1'b1, 5'h10, 5'h00, 16'h8140, 16'h0000, 1'b0);
    wait_rsp(n, "post_reset_write");
    check("post_reset_wire_word", last_word, 32'h5802_8140);

    repeat (4) @(posedge clk_50);
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
